// File: rtl/mem_access_unit.sv
// Load/store initiator for the 64-bit data_sram: one request at a time, doubleword-aligned
// SRAM cycles, read-modify-write for sub-doubleword stores, sign/zero-extended loads.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        data_sram_en,
  output logic        data_sram_wen,
  output logic [63:0] data_sram_addr,
  output logic [63:0] data_sram_wdata,
  input  logic [63:0] data_sram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR      = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        wen_q, wen_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        resp_valid_q, resp_valid_d;
  logic        req_ready_q, req_ready_d;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic mis;
    case (size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = off[0];
      2'd2:    mis = |off[1:0];
      2'd3:    mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [63:0] lane_mask(input logic [1:0] size);
    logic [63:0] m;
    case (size)
      2'd0:    m = 64'h0000_0000_0000_00FF;
      2'd1:    m = 64'h0000_0000_0000_FFFF;
      2'd2:    m = 64'h0000_0000_FFFF_FFFF;
      2'd3:    m = 64'hFFFF_FFFF_FFFF_FFFF;
      default: m = 64'h0000_0000_0000_0000;
    endcase
    return m;
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] rd, input logic [2:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [63:0] sh;
    logic [63:0] res;
    sh = rd >> {off, 3'b000};
    case (size)
      2'd0:    res = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
      2'd1:    res = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    res = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      2'd3:    res = sh;
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Only the addressed lane changes; the other bytes come from the SRAM read.
  function automatic logic [63:0] store_merge(input logic [63:0] rd, input logic [2:0] off,
                                              input logic [1:0] size, input logic [63:0] wd);
    logic [63:0] m;
    m = lane_mask(size);
    return (rd & ~(m << {off, 3'b000})) | ((wd & m) << {off, 3'b000});
  endfunction

  // Next-state and latched-request computation.
  always_comb begin
    state_d = state_q;
    wen_d   = wen_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 64'd0;
          if (is_misaligned(req_size, req_addr[2:0])) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (req_wen && (req_size == 2'd3)) begin
            err_d   = 1'b0;
            state_d = S_WR;
          end else begin
            err_d   = 1'b0;
            state_d = S_RD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (wen_q) begin
          wdata_d = store_merge(data_sram_rdata, addr_q[2:0], size_q, wdata_q);
          state_d = S_WR;
        end else begin
          rdata_d = load_extend(data_sram_rdata, addr_q[2:0], size_q, uns_q);
          state_d = S_RESP;
        end
      end
      S_WR: state_d = S_RESP;
      S_RESP: begin
        if (resp_ready) begin
          rdata_d = 64'd0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wen_q        <= 1'b0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      addr_q       <= 64'd0;
      wdata_q      <= 64'd0;
      rdata_q      <= 64'd0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      wen_q        <= wen_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      req_ready_q  <= req_ready_d;
    end
  end

  // SRAM port decode from the current state; quiet outside RD and WR.
  always_comb begin
    data_sram_en    = 1'b0;
    data_sram_wen   = 1'b0;
    data_sram_addr  = 64'd0;
    data_sram_wdata = 64'd0;
    case (state_q)
      S_RD: begin
        data_sram_en   = 1'b1;
        data_sram_addr = {addr_q[63:3], 3'b000};
      end
      S_WR: begin
        data_sram_en    = 1'b1;
        data_sram_wen   = 1'b1;
        data_sram_addr  = {addr_q[63:3], 3'b000};
        data_sram_wdata = wdata_q;
      end
      default: data_sram_en = 1'b0;
    endcase
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
